ss_sgr_fifo: RTL and testbench

- Receive-side data buffer directly downstream of the SG reader. The SG reader issues Wishbone buffer reads; this block captures the returned 64-bit beats into a FIFO.
- Drives ss_ready back to the SG reader so that a new burst starts only when there is room for a full burst.
- Presents the beats in order to the data consumer (copy/XOR engine) over a valid/ready handshake.

---
 rtl/ss_sgr_fifo.sv | 111 +++++++++++
 tb/tb_ss_sgr_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ss_sgr_fifo.sv
// ss_sgr_fifo: receive-side beat buffer between the SG reader and the data consumer.
// Captures 64-bit Wishbone read beats returned during the buffer-request phase,
// throttles new bursts via ss_ready, and presents beats in order with
// first-word fall-through on a valid/ready interface.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_cyc/we/ack           Wishbone handshake observed from the SG reader side
//   wbs_dat_o, wbs_dat64_o   returned read data, low and high words
//   sg_state                 SG reader debug state, [2:0] is the state code
//   ss_done                  operation done, flushes the buffer
//   ss_ready                 at least BURST free entries
//   dout, dout_valid         head beat and non-empty flag
//   dout_ready               consumer accepts the head beat
//   fifo_cnt                 occupancy 0..DEPTH
//   ovf                      sticky overflow flag
module ss_sgr_fifo #(
    parameter int unsigned AW      = 4,
    parameter int unsigned BURST   = 8,
    parameter logic [2:0]  ST_BREQ = 3'h3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc,
    input  logic          wbs_we,
    input  logic          wbs_ack,
    input  logic [31:0]   wbs_dat_o,
    input  logic [31:0]   wbs_dat64_o,
    input  logic [7:0]    sg_state,
    input  logic          ss_done,
    output logic          ss_ready,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_C = (AW+1)'(BURST);

    typedef enum logic {
        S_RUN = 1'b0,
        S_OVF = 1'b1
    } state_t;

    state_t         state;
    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic           clear;
    logic           cap;
    logic           rd;
    logic           full;
    logic           cap_acc;
    logic           drop;

    // Upper debug-state bits carry no meaning for this block.
    logic           unused_state_bits;
    assign unused_state_bits = ^sg_state[7:3];

    // Only read acks during the buffer-request phase carry payload data.
    assign cap     = wbs_cyc & wbs_ack & ~wbs_we & (sg_state[2:0] == ST_BREQ);
    assign full    = (count == DEPTH_C);
    assign rd      = dout_valid & dout_ready;
    // At full, a same-cycle read frees the slot so the new beat is still taken.
    assign cap_acc = cap & (~full | rd);
    assign drop    = cap & full & ~rd;
    assign clear   = wb_rst_i | ss_done;

    // Outputs derived from registered state only.
    assign dout_valid = (count != '0);
    assign dout       = mem[rd_ptr];
    assign fifo_cnt   = count;
    assign ss_ready   = (DEPTH_C - count) >= BURST_C;
    assign ovf        = (state == S_OVF);

    // Beat storage; contents are intentionally not reset.
    always_ff @(posedge wb_clk_i) begin
        if (cap_acc && !clear) begin
            mem[wr_ptr] <= {wbs_dat64_o, wbs_dat_o};
        end
    end

    // Pointers, occupancy and overflow state; reset and flush act identically.
    always_ff @(posedge wb_clk_i) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_RUN;
        end else begin
            if (cap_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(cap_acc) - (AW+1)'(rd);
            case (state)
                S_RUN:   if (drop) state <= S_OVF;
                S_OVF:   state <= S_OVF;
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_sgr_fifo.sv
// tb_ss_sgr_fifo: directed scenarios plus randomized traffic, compared every
// cycle against a queue-based model of the buffer.
module tb_ss_sgr_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        we;
    logic        ack;
    logic [31:0] dat_lo;
    logic [31:0] dat_hi;
    logic [7:0]  st;
    logic        done;
    logic        ss_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [4:0]  fifo_cnt;
    logic        ovf;

    always #5 clk = ~clk;

    ss_sgr_fifo dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc     (cyc),
        .wbs_we      (we),
        .wbs_ack     (ack),
        .wbs_dat_o   (dat_lo),
        .wbs_dat64_o (dat_hi),
        .sg_state    (st),
        .ss_done     (done),
        .ss_ready    (ss_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .fifo_cnt    (fifo_cnt),
        .ovf         (ovf)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] q[$];
    bit          ovf_m = 1'b0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, return after the falling edge.
    task automatic step(input bit c, input bit w, input bit a, input logic [7:0] s,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input bit rdy, input bit dn, input bit rs);
        bit r;
        bit cp;
        int n;
        cyc = c; we = w; ack = a; st = s; dat_lo = lo; dat_hi = hi;
        dout_ready = rdy; done = dn; rst = rs;
        @(posedge clk);
        if (rs || dn) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            n  = q.size();
            r  = (n != 0) && rdy;
            cp = c && a && !w && (s[2:0] == 3'd3);
            if (r) void'(q.pop_front());
            if (cp) begin
                if (n < 16 || r) q.push_back({hi, lo});
                else ovf_m = 1'b1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] i, input bit rdy);
        step(1'b1, 1'b0, 1'b1, 8'h03, i, 32'hA0 + i, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cnt",   64'(fifo_cnt),   64'(q.size()));
            chk("valid", 64'(dout_valid), 64'(q.size() != 0));
            chk("ready", 64'(ss_ready),   64'((16 - q.size()) >= 8));
            chk("ovf",   64'(ovf),        64'(ovf_m));
            if (q.size() != 0) chk("dout", dout, q[0]);
        end
    end

    initial begin
        int rdy_pct;
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_cnt",   64'(fifo_cnt),   64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_ready", 64'(ss_ready),   64'd1);
        chk("rst_ovf",   64'(ovf),        64'd0);

        // Basic flow: each beat visible one cycle after its ack.
        for (int i = 1; i <= 5; i++) begin
            beat(32'(i), 1'b1);
            chk("basic_dout",  dout, {32'hA0 + 32'(i), 32'(i)});
            chk("basic_valid", 64'(dout_valid), 64'd1);
        end
        idle(1'b1);
        chk("basic_empty", 64'(fifo_cnt), 64'd0);

        // Gating: descriptor-fetch acks are not captured.
        step(1'b1, 1'b0, 1'b1, 8'h02, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h02, 32'h12, 32'h23, 1'b0, 1'b0, 1'b0);
        beat(32'h33, 1'b0);
        chk("gate_cnt",  64'(fifo_cnt), 64'd1);
        chk("gate_dout", dout, 64'h000000D3_00000033);
        idle(1'b1);

        // Half fill and drain so the next fill wraps the pointers.
        for (int i = 0; i < 8; i++) beat(32'(100 + i), 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Threshold and overflow.
        for (int i = 1; i <= 17; i++) begin
            beat(32'(i), 1'b0);
            if (i == 8) begin
                chk("thr8_ready", 64'(ss_ready), 64'd1);
                chk("thr8_cnt",   64'(fifo_cnt), 64'd8);
            end
            if (i == 9)  chk("thr9_ready", 64'(ss_ready), 64'd0);
            if (i == 16) chk("full_ovf0",  64'(ovf), 64'd0);
            if (i == 17) begin
                chk("full_cnt", 64'(fifo_cnt), 64'd16);
                chk("full_ovf", 64'(ovf), 64'd1);
            end
        end
        for (int i = 1; i <= 16; i++) begin
            chk("drain_dout", dout, {32'hA0 + 32'(i), 32'(i)});
            idle(1'b1);
        end
        chk("drain_cnt", 64'(fifo_cnt), 64'd0);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_ovf", 64'(ovf), 64'd0);

        // Simultaneous capture and read at full.
        for (int i = 1; i <= 16; i++) beat(32'(200 + i), 1'b0);
        beat(32'h300, 1'b1);
        chk("sim_cnt", 64'(fifo_cnt), 64'd16);
        chk("sim_ovf", 64'(ovf), 64'd0);
        chk("sim_head", dout, {32'hA0 + 32'd202, 32'd202});
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("sim_last", dout, 64'h000003A0_00000300);
            idle(1'b1);
        end

        // Flush with a simultaneous capture, then reset mid-burst.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= 17; i++) beat(32'(400 + i), 1'b0);
            for (int i = 0; i < 10; i++) idle(1'b1);
            chk("pre_cnt", 64'(fifo_cnt), 64'd6);
            chk("pre_ovf", 64'(ovf), 64'd1);
            if (pass == 0) begin
                step(1'b1, 1'b0, 1'b1, 8'h03, 32'h55, 32'h66, 1'b1, 1'b1, 1'b0);
            end else begin
                beat(32'h500, 1'b0);
                step(1'b1, 1'b0, 1'b1, 8'h03, 32'h55, 32'h66, 1'b1, 1'b0, 1'b1);
            end
            chk("clr_cnt",   64'(fifo_cnt),   64'd0);
            chk("clr_valid", 64'(dout_valid), 64'd0);
            chk("clr_ovf",   64'(ovf),        64'd0);
            chk("clr_ready", 64'(ss_ready),   64'd1);
        end

        // Randomized traffic with varying consumer throughput.
        rdy_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] s;
            if (n % 250 == 0) rdy_pct = int'($urandom_range(5, 95));
            if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(0, 255));
            else s = {5'($urandom_range(0, 31)), 3'd3};
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0,
                 s, $urandom, $urandom,
                 int'($urandom_range(0, 99)) < rdy_pct,
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 799) == 0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
